// File: rtl/cam_dvp_frame_gen.sv
// rtl/cam_dvp_frame_gen.sv - DVP camera source emitting timed frames of deterministic test patterns
// All outputs are registered from the next-cycle position so p_data and href share an edge.
module cam_dvp_frame_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        p_clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic        cont_mode,
  input  logic [1:0]  pattern_sel,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LINE_LEN = H_ACTIVE + H_BLANK;
  localparam int CW       = $clog2(LINE_LEN);
  localparam int M1       = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int M2       = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int MAX_L    = (M1 > M2) ? M1 : M2;
  localparam int LW       = (MAX_L > 1) ? $clog2(MAX_L) : 1;
  localparam int VFP_EFF  = (VFP_LINES > 0) ? VFP_LINES : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] COL_HA   = CW'(H_ACTIVE);
  localparam logic [LW-1:0] L_VS     = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] L_VBP    = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] L_ACT    = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] L_VFP    = LW'(VFP_EFF - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  // With no front porch the frame ends on the last ACTIVE cycle.
  localparam state_t        S_FINAL = (VFP_LINES > 0) ? S_VFP : S_ACTIVE;
  localparam logic [LW-1:0] L_FINAL = (VFP_LINES > 0) ? L_VFP : L_ACT;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic [7:0]    r_byte_idx;
  logic [1:0]    r_pat;
  logic          r_rearm;

  state_t        w_nxt_state;
  logic [CW-1:0] w_nxt_col;
  logic [LW-1:0] w_nxt_line;
  logic [LW-1:0] w_line_last;
  logic          w_col_end;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_start;
  logic          w_href_nxt;
  logic          w_last_nxt;
  logic [7:0]    w_row8;
  logic [7:0]    w_col8;
  logic [7:0]    w_data;

  always_comb begin
    w_line_last = '0;
    case (r_state)
      S_VSYNC:  w_line_last = L_VS;
      S_VBP:    w_line_last = L_VBP;
      S_ACTIVE: w_line_last = L_ACT;
      S_VFP:    w_line_last = L_VFP;
      default:  w_line_last = '0;
    endcase
    w_col_end   = (r_col == COL_LAST);
    w_line_end  = (r_line == w_line_last);
    w_frame_end = w_col_end && w_line_end && (r_state == S_FINAL);
    w_start     = (r_state == S_IDLE) ? (enable && (cont_mode || r_rearm))
                                      : (w_frame_end && enable && cont_mode);

    w_nxt_state = r_state;
    w_nxt_col   = r_col + CW'(1);
    w_nxt_line  = r_line;
    if (r_state == S_IDLE) begin
      w_nxt_col  = '0;
      w_nxt_line = '0;
    end else if (w_col_end) begin
      w_nxt_col = '0;
      if (w_line_end) begin
        w_nxt_line = '0;
        case (r_state)
          S_VSYNC:  w_nxt_state = S_VBP;
          S_VBP:    w_nxt_state = S_ACTIVE;
          S_ACTIVE: w_nxt_state = (VFP_LINES > 0) ? S_VFP : S_IDLE;
          default:  w_nxt_state = S_IDLE;
        endcase
      end else begin
        w_nxt_line = r_line + LW'(1);
      end
    end
    if (w_start) begin
      w_nxt_state = S_VSYNC;
      w_nxt_col   = '0;
      w_nxt_line  = '0;
    end

    w_href_nxt = (w_nxt_state == S_ACTIVE) && (w_nxt_col < COL_HA);
    w_last_nxt = (w_nxt_state == S_FINAL) && (w_nxt_col == COL_LAST) && (w_nxt_line == L_FINAL);
    w_row8     = 8'(w_nxt_line);
    w_col8     = 8'(w_nxt_col);
    case (r_pat)
      2'd0:    w_data = r_byte_idx;
      2'd1:    w_data = w_col8;
      2'd2:    w_data = w_row8;
      default: w_data = {w_row8[3:0], w_col8[3:0]};
    endcase
  end

  always_ff @(posedge p_clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_line     <= '0;
      r_byte_idx <= '0;
      r_pat      <= '0;
      r_rearm    <= 1'b1;
      vsync      <= 1'b0;
      href       <= 1'b0;
      p_data     <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      r_state <= w_nxt_state;
      r_col   <= w_nxt_col;
      r_line  <= w_nxt_line;
      if (w_start) begin
        r_pat      <= pattern_sel;
        r_byte_idx <= '0;
        r_rearm    <= 1'b0;
      end else begin
        if (!enable)
          r_rearm <= 1'b1;
        if (w_href_nxt)
          r_byte_idx <= r_byte_idx + 8'd1;
      end
      vsync      <= (w_nxt_state == S_VSYNC);
      busy       <= (w_nxt_state != S_IDLE);
      href       <= w_href_nxt;
      p_data     <= w_href_nxt ? w_data : 8'h00;
      frame_done <= w_last_nxt;
      if (w_last_nxt)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_dvp_frame_gen.sv
// tb/tb_cam_dvp_frame_gen.sv - self-checking bench for cam_dvp_frame_gen with a frame-offset reference model
module tb_cam_dvp_frame_gen;

  localparam int HA    = 4;
  localparam int HB    = 2;
  localparam int VA    = 3;
  localparam int VSL   = 1;
  localparam int VBPL  = 1;
  localparam int VFPL  = 1;
  localparam int LL    = HA + HB;
  localparam int FRAME = LL * (VSL + VBPL + VA + VFPL);

  logic        p_clock;
  logic        resetn;
  logic        enable;
  logic        cont_mode;
  logic [1:0]  pattern_sel;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  cam_dvp_frame_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VSL), .VBP_LINES(VBPL), .VFP_LINES(VFPL)
  ) dut (
    .p_clock(p_clock), .resetn(resetn), .enable(enable), .cont_mode(cont_mode),
    .pattern_sel(pattern_sel), .vsync(vsync), .href(href), .p_data(p_data),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial p_clock = 1'b0;
  always #5 p_clock = ~p_clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: position is just the cycle offset inside the frame (-1 = idle).
  int          m_t;
  logic [1:0]  m_pat;
  bit          m_rearm;
  logic [15:0] m_cnt;

  int          cap_vs_n, cap_vs_first, cap_first_h, cap_fd_idx;
  logic [7:0]  cap_q[$];

  typedef struct {
    logic        en;
    logic        cm;
    logic [1:0]  ps;
    int          n;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_t = -1; m_pat = 2'd0; m_rearm = 1'b1; m_cnt = 16'd0;
  endtask

  task automatic model_edge(input logic en, input logic cm, input logic [1:0] ps);
    bit st;
    if (m_t < 0) st = en && (cm || m_rearm);
    else         st = (m_t == FRAME - 1) && en && cm;
    if (st) begin
      m_t = 0; m_pat = ps; m_rearm = 1'b0;
    end else begin
      if (m_t == FRAME - 1) m_t = -1;
      else if (m_t >= 0) m_t++;
      if (!en) m_rearm = 1'b1;
    end
    if (m_t == FRAME - 1) m_cnt++;
  endtask

  task automatic check_outputs(input string tag);
    logic e_v, e_h, e_b, e_fd;
    logic [7:0] e_d;
    int ln, col, a;
    e_v = 0; e_h = 0; e_b = 0; e_fd = 0; e_d = 8'h00;
    if (m_t >= 0) begin
      e_b  = 1;
      ln   = m_t / LL;
      col  = m_t % LL;
      e_v  = (ln < VSL);
      e_fd = (m_t == FRAME - 1);
      a    = ln - VSL - VBPL;
      if (a >= 0 && a < VA && col < HA) begin
        e_h = 1;
        case (m_pat)
          2'd0:    e_d = 8'(a * HA + col);
          2'd1:    e_d = 8'(col);
          2'd2:    e_d = 8'(a);
          default: e_d = {4'(a), 4'(col)};
        endcase
      end
    end
    checks++;
    if ({vsync, href, p_data, busy, frame_done, frame_cnt} !== {e_v, e_h, e_d, e_b, e_fd, m_cnt}) begin
      errors++;
      $display("FAIL %s cycle %0d: got vs=%b hr=%b d=%h busy=%b fd=%b cnt=%0d expected vs=%b hr=%b d=%h busy=%b fd=%b cnt=%0d",
               tag, cyc, vsync, href, p_data, busy, frame_done, frame_cnt, e_v, e_h, e_d, e_b, e_fd, m_cnt);
    end
  endtask

  task automatic step(input logic en, input logic cm, input logic [1:0] ps);
    enable = en; cont_mode = cm; pattern_sel = ps;
    @(posedge p_clock);
    cyc++;
    if (resetn) model_edge(en, cm, ps);
    #1;
    check_outputs("model");
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    resetn = 1'b1;
  endtask

  task automatic capture_frame(input logic cm, input logic [1:0] ps);
    cap_vs_n = 0; cap_vs_first = -1; cap_first_h = -1; cap_fd_idx = -1;
    cap_q.delete();
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1, cm, ps);
      if (vsync) begin
        cap_vs_n++;
        if (cap_vs_first < 0) cap_vs_first = k;
      end
      if (href) begin
        if (cap_first_h < 0) cap_first_h = k;
        cap_q.push_back(p_data);
      end
      if (frame_done) cap_fd_idx = k;
    end
  endtask

  task automatic check_pattern0_frame(input string tag);
    chk({tag, "_vs_first"}, cap_vs_first, 0);
    chk({tag, "_vs_cycles"}, cap_vs_n, VSL * LL);
    chk({tag, "_first_href"}, cap_first_h, (VSL + VBPL) * LL);
    chk({tag, "_bytes"}, cap_q.size(), 12);
    for (int i = 0; i < cap_q.size() && i < 12; i++)
      chk({tag, "_byte"}, cap_q[i], i);
    chk({tag, "_fd_idx"}, cap_fd_idx, FRAME - 1);
  endtask

  initial begin
    logic en_r, cm_r;
    tbl[0] = '{en: 1'b0, cm: 1'b0, ps: 2'd0, n: 20, exp_busy: 1'b0, exp_cnt: 16'd0};
    tbl[1] = '{en: 1'b1, cm: 1'b0, ps: 2'd0, n: 40, exp_busy: 1'b0, exp_cnt: 16'd1};
    tbl[2] = '{en: 1'b0, cm: 1'b0, ps: 2'd0, n: 1,  exp_busy: 1'b0, exp_cnt: 16'd1};
    tbl[3] = '{en: 1'b1, cm: 1'b0, ps: 2'd1, n: 40, exp_busy: 1'b0, exp_cnt: 16'd2};
    tbl[4] = '{en: 1'b1, cm: 1'b1, ps: 2'd3, n: 73, exp_busy: 1'b1, exp_cnt: 16'd4};
    tbl[5] = '{en: 1'b0, cm: 1'b1, ps: 2'd2, n: 20, exp_busy: 1'b1, exp_cnt: 16'd4};
    tbl[6] = '{en: 1'b0, cm: 1'b1, ps: 2'd2, n: 20, exp_busy: 1'b0, exp_cnt: 16'd5};

    resetn = 1'b0; enable = 1'b0; cont_mode = 1'b0; pattern_sel = 2'd0;
    model_reset();
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].en, tbl[i].cm, tbl[i].ps);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_cnt", i), frame_cnt, tbl[i].exp_cnt);
    end

    // Single-shot frame, pattern 0: timing and byte sequence.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 2'd0);
    capture_frame(1'b0, 2'd0);
    check_pattern0_frame("f1");
    chk("f1_cnt", frame_cnt, 1);
    repeat (5) step(1'b1, 1'b0, 2'd0);
    chk("f1_idle_held", busy, 0);

    // Enable rises exactly on the frame_done cycle with cont_mode=0.
    step(1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    chk("coinc_start_vs", vsync, 1);
    repeat (FRAME - 1) step(1'b0, 1'b0, 2'd0);
    chk("coinc_fd", frame_done, 1);
    step(1'b1, 1'b0, 2'd0);
    chk("coinc_idle_first", busy, 0);
    step(1'b1, 1'b0, 2'd0);
    chk("coinc_restart_vs", vsync, 1);
    repeat (FRAME) step(1'b0, 1'b0, 2'd0);
    chk("coinc_cnt", frame_cnt, 3);

    // Continuous mode, pattern 3, then enable drop mid-ACTIVE.
    do_reset();
    step(1'b0, 1'b1, 2'd3);
    capture_frame(1'b1, 2'd3);
    chk("p3_bytes", cap_q.size(), 12);
    for (int i = 8; i < 12 && i < cap_q.size(); i++)
      chk("p3_line2", cap_q[i], 8'h20 + (i - 8));
    chk("p3_fd_idx", cap_fd_idx, FRAME - 1);
    step(1'b1, 1'b1, 2'd0);
    chk("b2b_vsync", vsync, 1);
    chk("b2b_cnt", frame_cnt, 1);
    repeat (14) step(1'b1, 1'b1, 2'd0);
    chk("drop_href", href, 1);
    repeat (21) step(1'b0, 1'b1, 2'd0);
    chk("drop_fd", frame_done, 1);
    step(1'b0, 1'b1, 2'd0);
    chk("drop_busy", busy, 0);
    chk("drop_cnt", frame_cnt, 2);

    // Reset asserted while href is high.
    do_reset();
    repeat (2) step(1'b0, 1'b0, 2'd0);
    repeat (14) step(1'b1, 1'b0, 2'd0);
    chk("mid_href_pre", href, 1);
    do_reset();
    chk("mid_href_post", href, 0);
    chk("mid_cnt_post", frame_cnt, 0);
    step(1'b0, 1'b0, 2'd0);
    capture_frame(1'b0, 2'd0);
    check_pattern0_frame("f_after_rst");

    // Randomised run against the model.
    en_r = 1'b0; cm_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      if ($urandom_range(0, 39) == 0) cm_r = ~cm_r;
      if ($urandom_range(0, 1499) == 0) do_reset();
      step(en_r, cm_r, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
